// File: rtl/perf_bcd_conv.sv
// perf_bcd_conv: sequential double-dabble binary-to-BCD converter with saturation at all-9s.
module perf_bcd_conv #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_value,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  busy
);
    localparam int CW = $clog2(IN_W);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t            state, state_nxt;
    logic [39:0]       scratch, adj;
    logic [IN_W-1:0]   shreg;
    logic [CW-1:0]     cnt;
    logic              ovf, last;
    for (genvar g = 0; g < 10; g++) begin : g_dig
        assign adj[4*g +: 4] = scratch[4*g +: 4] >= 4'd5 ? scratch[4*g +: 4] + 4'd3 : scratch[4*g +: 4];
    end
    assign ovf      = |(scratch >> (4*DIGITS));
    assign last     = cnt == CW'(IN_W-1);
    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
                    state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            scratch   <= '0;
            shreg     <= '0;
            cnt       <= '0;
            bcd       <= {DIGITS{4'hF}};
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= state == DONE;
            if (state == IDLE && in_valid) begin
                shreg   <= in_value;
                scratch <= '0;
                cnt     <= '0;
            end
            // adjust-then-shift; the shift register MSB feeds the ones digit
            if (state == SHIFT) begin
                {scratch, shreg} <= {adj, shreg} << 1;
                cnt              <= cnt + 1'b1;
            end
            if (state == DONE) begin
                overflow <= ovf;
                bcd      <= ovf ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
            end
        end
    end
endmodule
